mips_bus_arbiter: RTL

Two-master, one-slave arbiter for the CPU's Avalon-style memory bus (address/read/write/writedata/byteenable/readdata/waitrequest). Master 0 is the instruction-fetch port and master 1 is the data port (or the bench loader); the slave is the RAM behind the 0xBFC00000 window. The block holds one grant until the slave completes, rebases addresses to RAM offsets, and terminates out-of-window and hung transfers itself.

---
 rtl/mips_bus_pkg.sv | 36 +++
 rtl/mips_bus_watchdog.sv | 43 ++++
 rtl/mips_bus_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/mips_bus_pkg.sv
// Shared types and defaults for the two-master MIPS memory-bus arbiter.
package mips_bus_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      ERRRESP = 2'd2
   } arb_state_t;

   localparam logic [31:0] DEF_BASE_ADDR  = 32'hBFC00000;
   localparam logic [31:0] DEF_LIMIT_ADDR = 32'hBFC07FFF;
   localparam logic [31:0] DEF_ERR_DATA   = 32'h00000000;
   localparam int          DEF_S_ADDR_W   = 16;
   localparam int          DEF_TIMEOUT    = 64;

   typedef struct packed {
      logic [31:0] address;
      logic        read;
      logic        write;
      logic [31:0] writedata;
      logic [3:0]  byteenable;
   } m_req_t;

   function automatic logic in_window(
      input logic [31:0] addr,
      input logic [31:0] lo,
      input logic [31:0] hi
   );
      return (addr >= lo) && (addr <= hi);
   endfunction

   function automatic int wd_width(input int timeout);
      return (timeout > 1) ? $clog2(timeout) : 1;
   endfunction

endpackage

// File: rtl/mips_bus_watchdog.sv
// Transfer watchdog: counts stalled cycles and flags the last allowed one.
module mips_bus_watchdog
   import mips_bus_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT,
   parameter int CW      = wd_width(TIMEOUT)
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clear,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          enable,
   output logic          expire
);

   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (enable) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A zero TIMEOUT disables the watchdog entirely.
   assign expire = (TIMEOUT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/mips_bus_arbiter.sv
// Round-robin two-master arbiter for the boot-RAM window, with decode,
// protocol and timeout termination handled locally.
module mips_bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = DEF_BASE_ADDR,
   parameter logic [31:0] LIMIT_ADDR = DEF_LIMIT_ADDR,
   parameter int          S_ADDR_W   = DEF_S_ADDR_W,
   parameter int          TIMEOUT    = DEF_TIMEOUT,
   parameter logic [31:0] ERR_DATA   = DEF_ERR_DATA
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic [31:0]         m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [31:0]         m0_writedata,
   input  logic [3:0]          m0_byteenable,
   output logic [31:0]         m0_readdata,
   output logic                m0_waitrequest,
   input  logic [31:0]         m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [31:0]         m1_writedata,
   input  logic [3:0]          m1_byteenable,
   output logic [31:0]         m1_readdata,
   output logic                m1_waitrequest,
   output logic [S_ADDR_W-1:0] s_address,
   output logic                s_read,
   output logic                s_write,
   output logic [31:0]         s_writedata,
   output logic [3:0]          s_byteenable,
   input  logic [31:0]         s_readdata,
   input  logic                s_waitrequest,
   output logic                err_decode,
   output logic                err_timeout,
   output logic                err_protocol,
   output logic                busy
);

   localparam int WD_W = wd_width(TIMEOUT);

   arb_state_t state_q, state_d;
   logic       grant_q, grant_d;
   logic       last_q, last_d;
   logic       wr_sup_q, wr_sup_d;
   logic       err_dec_q, err_dec_d;
   logic       err_to_q, err_to_d;
   logic       err_pr_q, err_pr_d;

   m_req_t      m0_req, m1_req, gm;
   logic        req0, req1, win;
   logic        win_rd, win_wr;
   logic [31:0] win_addr;
   logic        wd_clr, wd_load, wd_en, wd_exp;

   assign m0_req = '{address: m0_address, read: m0_read,
                     write: m0_write, writedata: m0_writedata,
                     byteenable: m0_byteenable};
   assign m1_req = '{address: m1_address, read: m1_read,
                     write: m1_write, writedata: m1_writedata,
                     byteenable: m1_byteenable};

   assign req0 = m0_read | m0_write;
   assign req1 = m1_read | m1_write;
   // On a tie the master not served last wins.
   assign win      = (req0 & req1) ? ~last_q : req1;
   assign win_addr = win ? m1_address : m0_address;
   assign win_rd   = win ? m1_read : m0_read;
   assign win_wr   = win ? m1_write : m0_write;
   assign gm       = grant_q ? m1_req : m0_req;

   mips_bus_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CW      (WD_W)
   ) u_wd (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (wd_clr),
      .load     (wd_load),
      .load_val ('0),
      .enable   (wd_en),
      .expire   (wd_exp)
   );

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      last_d    = last_q;
      wr_sup_d  = wr_sup_q;
      err_dec_d = err_dec_q;
      err_to_d  = err_to_q;
      err_pr_d  = err_pr_q;
      wd_clr    = 1'b0;
      wd_load   = 1'b0;
      wd_en     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               grant_d  = win;
               wr_sup_d = win_rd & win_wr;
               wd_load  = 1'b1;
               if (win_rd & win_wr) begin
                  err_pr_d = 1'b1;
               end
               if (in_window(win_addr, BASE_ADDR, LIMIT_ADDR)) begin
                  state_d = BUSY;
               end else begin
                  state_d   = ERRRESP;
                  err_dec_d = 1'b1;
               end
            end
         end
         BUSY: begin
            if (!(gm.read | gm.write)) begin
               err_pr_d = 1'b1;
               state_d  = IDLE;
               last_d   = grant_q;
               wd_clr   = 1'b1;
            end else if (!s_waitrequest) begin
               state_d = IDLE;
               last_d  = grant_q;
               wd_clr  = 1'b1;
            end else if (wd_exp) begin
               state_d  = ERRRESP;
               err_to_d = 1'b1;
               wd_clr   = 1'b1;
            end else begin
               wd_en = 1'b1;
            end
         end
         ERRRESP: begin
            state_d = IDLE;
            last_d  = grant_q;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      s_address      = S_ADDR_W'(gm.address - BASE_ADDR);
      s_writedata    = gm.writedata;
      s_byteenable   = gm.byteenable;
      s_read         = 1'b0;
      s_write        = 1'b0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      m0_readdata    = '0;
      m1_readdata    = '0;
      unique case (state_q)
         BUSY: begin
            s_read  = gm.read;
            s_write = gm.write & ~wr_sup_q;
            if (grant_q) begin
               m1_waitrequest = s_waitrequest;
               m1_readdata    = s_readdata;
            end else begin
               m0_waitrequest = s_waitrequest;
               m0_readdata    = s_readdata;
            end
         end
         ERRRESP: begin
            if (grant_q) begin
               m1_waitrequest = 1'b0;
               m1_readdata    = ERR_DATA;
            end else begin
               m0_waitrequest = 1'b0;
               m0_readdata    = ERR_DATA;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         grant_q   <= 1'b0;
         last_q    <= 1'b1;
         wr_sup_q  <= 1'b0;
         err_dec_q <= 1'b0;
         err_to_q  <= 1'b0;
         err_pr_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         last_q    <= last_d;
         wr_sup_q  <= wr_sup_d;
         err_dec_q <= err_dec_d;
         err_to_q  <= err_to_d;
         err_pr_q  <= err_pr_d;
      end
   end

   assign err_decode   = err_dec_q;
   assign err_timeout  = err_to_q;
   assign err_protocol = err_pr_q;
   assign busy         = (state_q != IDLE);

endmodule
